// File: rtl/mix_pkg.sv
// Shared types and constants for the I2S mic-pair mixer.
// Slot identity and default sample width / saturation rails.
package mix_pkg;

  localparam int WIDTH_DEF = 18;

  localparam logic [WIDTH_DEF-1:0] SAT_MAX =
    {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic [WIDTH_DEF-1:0] SAT_MIN =
    {1'b1, {(WIDTH_DEF-1){1'b0}}};

  typedef enum logic {
    SLOT_L = 1'b0,
    SLOT_R = 1'b1
  } slot_e;

endpackage

// File: rtl/i2s_slot_capture.sv
// One-slot I2S deserialiser, reused for left and right slots.
// Skips the delay bit, captures WIDTH bits, zero-pads short slots.
module i2s_slot_capture
  import mix_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SLOT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lr_edge,
  input  logic             sd,
  output logic [WIDTH-1:0] word,
  output logic             full,
  output logic             short_end
);

  localparam int CMAX = (SLOT_BITS > WIDTH) ? SLOT_BITS : WIDTH;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_W = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_L = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] cap_sr;
  logic             armed;
  logic             shift_en;

  assign shift_en  = armed & ~lr_edge & (bit_cnt != CNT_W);
  assign short_end = lr_edge & armed & (bit_cnt != CNT_W);
  assign word      = cap_sr << (CNT_W - bit_cnt);

  // Bit counter and MSB-first shift register for the current slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      cap_sr  <= '0;
      armed   <= 1'b0;
      full    <= 1'b0;
    end else begin
      full <= shift_en & (bit_cnt == CNT_L);
      if (lr_edge) begin
        armed   <= 1'b1;
        bit_cnt <= '0;
        cap_sr  <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        cap_sr  <= {cap_sr[WIDTH-2:0], sd};
      end
    end
  end

endmodule

// File: rtl/i2s_pair_mixer.sv
// Stereo mic pair mixer: deserialise A/B, sum (saturate or halve),
// and re-serialise MSB-first aligned to the word-select rise.
module i2s_pair_mixer
  import mix_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SLOT_BITS = 32,
  parameter int HALVE     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lr_clk,
  input  logic sd,
  output logic sum_res,
  output logic last_shift,
  output logic sample_vld,
  output logic clip,
  output logic short_err
);

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic             prev_lr;
  logic             rise;
  logic             lr_edge;
  slot_e            slot;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_n;
  logic [WIDTH-1:0] out_sr;
  logic [WIDTH:0]   sum_w;
  logic             full;
  logic             short_end;
  logic             take;
  logic             a_vld;
  logic             clip_n;

  assign rise    = lr_clk & ~prev_lr;
  assign lr_edge = lr_clk ^ prev_lr;
  assign slot    = prev_lr ? SLOT_R : SLOT_L;
  assign take    = full | short_end;

  i2s_slot_capture #(
    .WIDTH    (WIDTH),
    .SLOT_BITS(SLOT_BITS)
  ) u_cap (
    .clk      (clk),
    .rst_n    (rst_n),
    .lr_edge  (lr_edge),
    .sd       (sd),
    .word     (word),
    .full     (full),
    .short_end(short_end)
  );

  // Widen, add, then either halve or clamp to the signed rails
  always_comb begin
    sum_w  = {word_a[WIDTH-1], word_a} + {word[WIDTH-1], word};
    sum_n  = sum_w[WIDTH-1:0];
    clip_n = 1'b0;
    if (HALVE != 0) begin
      sum_n = sum_w[WIDTH:1];
    end else if (sum_w[WIDTH] != sum_w[WIDTH-1]) begin
      clip_n = 1'b1;
      sum_n  = sum_w[WIDTH] ? MIN_V : MAX_V;
    end
  end

  // Word-select tracking, pair latch, sum register and out shifter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_lr    <= 1'b0;
      word_a     <= '0;
      a_vld      <= 1'b0;
      sum_q      <= '0;
      sample_vld <= 1'b0;
      clip       <= 1'b0;
      short_err  <= 1'b0;
      out_sr     <= '0;
    end else begin
      prev_lr    <= lr_clk;
      sample_vld <= 1'b0;
      clip       <= 1'b0;
      if (take && slot == SLOT_L) begin
        word_a <= word;
        a_vld  <= 1'b1;
      end
      if (take && slot == SLOT_R && a_vld) begin
        sum_q      <= sum_n;
        sample_vld <= 1'b1;
        clip       <= clip_n;
      end
      if (short_end) short_err <= 1'b1;
      if (rise) out_sr <= {sum_q[WIDTH-2:0], 1'b0};
      else      out_sr <= out_sr << 1;
    end
  end

  assign sum_res    = sum_q[WIDTH-1];
  assign last_shift = out_sr[WIDTH-1];

endmodule

// File: tb/tb_i2s_pair_mixer.sv
// Bench for i2s_pair_mixer: saturating and halving instances share
// one stimulus; a word-level model predicts every output each cycle.
module tb_i2s_pair_mixer;
  import mix_pkg::*;

  localparam int W    = 18;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_n, lr_clk, sd;
  logic [1:0] o_sr, o_ls, o_vld, o_clip, o_serr;

  always #5 clk = ~clk;

  i2s_pair_mixer #(.WIDTH(W), .SLOT_BITS(32), .HALVE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .lr_clk(lr_clk), .sd(sd),
    .sum_res(o_sr[0]), .last_shift(o_ls[0]),
    .sample_vld(o_vld[0]), .clip(o_clip[0]),
    .short_err(o_serr[0])
  );

  i2s_pair_mixer #(.WIDTH(W), .SLOT_BITS(32), .HALVE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .lr_clk(lr_clk), .sd(sd),
    .sum_res(o_sr[1]), .last_shift(o_ls[1]),
    .sample_vld(o_vld[1]), .clip(o_clip[1]),
    .short_err(o_serr[1])
  );

  bit lr_q[$];
  bit sd_q[$];
  bit rst_q[$];
  int rise_q[$];

  logic e_vld [2][MAXC];
  logic e_clip[2][MAXC];
  logic e_sr  [2][MAXC];
  logic e_ls  [2][MAXC];
  logic e_serr[2][MAXC];
  logic d_sr  [2][MAXC];
  logic d_ls  [2][MAXC];
  logic d_serr[2][MAXC];
  bit   cq0[$];
  bit   cq1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic add_rst(input int n);
    for (int i = 0; i < n; i++) begin
      rst_q.push_back(1'b0);
      lr_q.push_back(1'b1);
      sd_q.push_back(1'($urandom));
    end
  endtask

  task automatic slot(input bit lvl, input int len,
                      input logic [W-1:0] w);
    if (lvl) rise_q.push_back(lr_q.size());
    for (int i = 0; i < len; i++) begin
      rst_q.push_back(1'b1);
      lr_q.push_back(lvl);
      if (i >= 1 && i <= W) sd_q.push_back(w[W-i]);
      else sd_q.push_back(1'($urandom));
    end
  endtask

  task automatic pair(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int llen, input int rlen,
                      output int ridx);
    slot(1'b0, llen, a);
    ridx = rise_q.size();
    slot(1'b1, rlen, b);
  endtask

  function automatic int rnd_len();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 32;
    if (r < 8) return int'($urandom_range(1, 18));
    return int'($urandom_range(20, 40));
  endfunction

  task automatic mix(input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit halve, output logic [W-1:0] r,
                     output bit cl);
    int sa, sb, s, hi, lo;
    hi = int'(SAT_MAX);
    lo = -hi - 1;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb;
    cl = 1'b0;
    if (halve) s = s >>> 1;
    else if (s > hi) begin s = hi; cl = 1'b1; end
    else if (s < lo) begin s = lo; cl = 1'b1; end
    r = s[W-1:0];
  endtask

  task automatic run_model();
    bit prev, armed, lvl, a_vld, has_rise, serr, edg, vld;
    int start, rise_c, n;
    logic [W-1:0] a, wd, res;
    logic [W-1:0] sq[2];
    logic [W-1:0] sqb[2];
    logic [W-1:0] rw[2];
    bit cl[2];
    bit c1;
    prev = 0; armed = 0; lvl = 0; a_vld = 0; has_rise = 0;
    serr = 0; start = 0; rise_c = 0; a = '0;
    sq[0] = '0; sq[1] = '0; rw[0] = '0; rw[1] = '0;
    for (int c = 0; c < lr_q.size(); c++) begin
      vld = 0; cl[0] = 0; cl[1] = 0;
      if (!rst_q[c]) begin
        prev = 0; armed = 0; a_vld = 0; has_rise = 0; serr = 0;
        a = '0; sq[0] = '0; sq[1] = '0;
      end else begin
        edg = (lr_q[c] != prev);
        sqb[0] = sq[0]; sqb[1] = sq[1];
        if (armed) begin
          n = c - start - 1;
          if (n == W || (edg && n < W)) begin
            wd = '0;
            for (int i = 0; i < n && i < W; i++)
              wd[W-1-i] = sd_q[start+1+i];
            if (n < W) serr = 1;
            if (!lvl) begin
              a = wd; a_vld = 1;
            end else if (a_vld) begin
              for (int d = 0; d < 2; d++) begin
                mix(a, wd, d[0], res, c1);
                sq[d] = res; cl[d] = c1;
              end
              vld = 1;
            end
          end
        end
        if (edg) begin
          if (lr_q[c]) begin
            has_rise = 1; rise_c = c;
            rw[0] = sqb[0]; rw[1] = sqb[1];
          end
          start = c; lvl = lr_q[c]; armed = 1;
        end
        prev = lr_q[c];
      end
      for (int d = 0; d < 2; d++) begin
        e_vld[d][c]  = vld;
        e_clip[d][c] = cl[d];
        e_sr[d][c]   = sq[d][W-1];
        e_serr[d][c] = serr;
        if (has_rise && c - rise_c <= W - 2)
          e_ls[d][c] = rw[d][W-2-(c-rise_c)];
        else
          e_ls[d][c] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input int d, input int c,
                     input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d got %b expected %b",
               nm, d, c, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [W-1:0] get_word(input int d, input int r);
    logic [W-1:0] w;
    w[W-1] = d_sr[d][r-1];
    for (int k = 0; k < W - 1; k++) w[W-2-k] = d_ls[d][r+k];
    return w;
  endfunction

  initial begin
    int r0, r1, r2, r3, r4, r5, r6, rr, r7, r8, tmp, nc;
    logic [W-1:0] ex0[8];
    logic [W-1:0] ex1[8];
    int ri[8];
    bit c0e[5];
    logic g;

    add_rst(3);
    r0 = rise_q.size();
    slot(1'b1, 32, W'($urandom));
    pair(18'h00010, 18'h00020, 32, 32, r1);
    pair(18'h1FFFF, 18'h00001, 32, 32, r2);
    pair(18'h20000, 18'h3FFFF, 32, 32, r3);
    pair(18'h1FFFF, 18'h1FFFF, 32, 32, r4);
    pair(18'h12345, 18'h003FF, 32, 11, r5);
    pair(18'h00000, 18'h00000, 32, 32, r6);
    slot(1'b0, 32, 18'h00100);
    slot(1'b1, 15, W'($urandom));
    add_rst(1);
    rr = rise_q.size();
    slot(1'b1, 20, W'($urandom));
    pair(18'h00005, 18'h00007, 32, 32, r7);
    pair(W'($urandom), W'($urandom), 32, 32, r8);
    for (int i = 0; i < 24; i++)
      pair(W'($urandom), W'($urandom), rnd_len(), rnd_len(), tmp);
    pair(18'h0, 18'h0, 32, 32, tmp);
    pair(18'h0, 18'h0, 32, 32, tmp);

    nc = lr_q.size();
    if (nc > MAXC) begin
      $display("FAIL stim_len got %0d limit %0d", nc, MAXC);
      $fatal(1, "stimulus too long");
    end
    run_model();

    for (int c = 0; c < nc; c++) begin
      rst_n  = rst_q[c];
      lr_clk = lr_q[c];
      sd     = sd_q[c];
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        d_sr[d][c]   = o_sr[d];
        d_ls[d][c]   = o_ls[d];
        d_serr[d][c] = o_serr[d];
        chk("sample_vld", d, c, o_vld[d], e_vld[d][c]);
        chk("sum_res", d, c, o_sr[d], e_sr[d][c]);
        chk("last_shift", d, c, o_ls[d], e_ls[d][c]);
        chk("short_err", d, c, o_serr[d], e_serr[d][c]);
        if (e_vld[d][c]) chk("clip", d, c, o_clip[d], e_clip[d][c]);
      end
      if (o_vld[0]) cq0.push_back(o_clip[0]);
      if (o_vld[1]) cq1.push_back(o_clip[1]);
    end

    ri[0] = r0; ri[1] = r2; ri[2] = r3; ri[3] = r4;
    ri[4] = r5; ri[5] = r6; ri[6] = rr; ri[7] = r8;
    ex0 = '{18'h00000, 18'h00030, 18'h1FFFF, 18'h20000,
            18'h1FFFF, 18'h12645, 18'h00000, 18'h0000C};
    ex1 = '{18'h00000, 18'h00018, 18'h10000, 18'h2FFFF,
            18'h1FFFF, 18'h09322, 18'h00000, 18'h00006};
    for (int k = 0; k < 8; k++) begin
      chkw($sformatf("word_sat_%0d", k),
           get_word(0, rise_q[ri[k]]), ex0[k]);
      chkw($sformatf("word_half_%0d", k),
           get_word(1, rise_q[ri[k]]), ex1[k]);
    end
    chkw("zero_before_pair", get_word(0, rise_q[r7]), 18'h0);

    c0e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      g = (i < cq0.size()) ? logic'(cq0[i]) : 1'bx;
      chk("clip_lit_sat", 0, i, g, c0e[i]);
      g = (i < cq1.size()) ? logic'(cq1[i]) : 1'bx;
      chk("clip_lit_half", 1, i, g, 1'b0);
    end
    chk("short_err_set", 0, rise_q[r6], d_serr[0][rise_q[r6]], 1'b1);
    chk("short_err_rst", 0, rise_q[rr], d_serr[0][rise_q[rr]], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
